// File: rtl/alu_to_reg_writeback.sv
// alu_to_reg_writeback: picks the write-back source, waits for and aligns load data, and drives one registered register-file write.
// Ports: clk, rst_n (async, active-low); wb_start/wb_sel/reg_write/rd_addr/funct3 describe the retiring instruction;
// alu_result/pc_plus4/immediate/mem_rdata/mem_rvalid are the data sources; rf_we/rf_waddr/rf_wdata form the write port;
// stall, wb_done, load_misalign and load_timeout report status. Define WB_LOAD_TIMEOUT_EN to bound the load wait.
module alu_to_reg_writeback #(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_start,
  input  logic [1:0]      wb_sel,
  input  logic            reg_write,
  input  logic [4:0]      rd_addr,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [XLEN-1:0] immediate,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_rvalid,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            stall,
  output logic            wb_done,
  output logic            load_misalign,
  output logic            load_timeout
);
  if (XLEN != 32) $error("alu_to_reg_writeback supports XLEN=32 only");
  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 32) $error("TIMEOUT_CYC must fit the 5-bit wait counter");
  typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE} state_t;
  state_t          state_q, state_d;
  logic [4:0]      waddr_q, waddr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            we_q, we_d, mis_q, mis_d, to_q, to_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;
  logic            is_load, mis_start, expired;
  logic [XLEN-1:0] lshift, ldata;
`ifdef WB_LOAD_TIMEOUT_EN
  logic [4:0] cnt_q;
  // Held at zero outside WAIT_MEM, so it is already clear on entry.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= (state_q == WAIT_MEM) ? cnt_q + 5'd1 : '0;
  assign expired = (state_q == WAIT_MEM) && (cnt_q == 5'(TIMEOUT_CYC - 1));
`else
  assign expired = 1'b0;
`endif
  // funct3[1:0]: 00 byte, 01 half, anything else behaves as a word.
  assign is_load   = wb_sel == 2'b01;
  assign mis_start = (funct3[1:0] == 2'b01) ? alu_result[0] : (funct3[1:0] != 2'b00) && (|alu_result[1:0]);
  assign lshift    = mem_rdata >> {off_q[1], off_q[0] & ~f3_q[0], 3'b000};
  assign ldata     = (f3_q[1:0] == 2'b00) ? {{(XLEN-8){lshift[7] & ~f3_q[2]}}, lshift[7:0]} :
                     (f3_q[1:0] == 2'b01) ? {{(XLEN-16){lshift[15] & ~f3_q[2]}}, lshift[15:0]} : mem_rdata;
  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    mis_d   = mis_q;
    to_d    = to_q;
    f3_d    = f3_q;
    off_d   = off_q;
    if (state_q == IDLE && wb_start) begin
      mis_d   = is_load && mis_start;
      to_d    = 1'b0;
      we_d    = reg_write && (|rd_addr) && !(is_load && mis_start);
      f3_d    = funct3;
      off_d   = alu_result[1:0];
      waddr_d = (is_load && mis_start) ? waddr_q : rd_addr;
      wdata_d = is_load ? wdata_q : (wb_sel == 2'b00) ? alu_result : (wb_sel == 2'b10) ? pc_plus4 : immediate;
      state_d = (is_load && !mis_start) ? WAIT_MEM : WRITE;
    end else if (state_q == WAIT_MEM && mem_rvalid) begin
      wdata_d = ldata;
      state_d = WRITE;
    end else if (expired) begin
      we_d    = 1'b0;
      to_d    = 1'b1;
      state_d = WRITE;
    end else if (state_q == WRITE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      to_q    <= 1'b0;
      f3_q    <= '0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      mis_q   <= mis_d;
      to_q    <= to_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
    end
  assign stall         = state_q != IDLE;
  assign wb_done       = state_q == WRITE;
  assign rf_we         = wb_done && we_q;
  assign load_misalign = wb_done && mis_q;
  assign load_timeout  = wb_done && to_q;
  assign rf_waddr      = waddr_q;
  assign rf_wdata      = wdata_q;
endmodule
